// File: rtl/branch_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_pkg
// Description : Shared definitions for the branch condition unit. Holds the
//               condition-code encodings, the controller state enum and the
//               default taken-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_cond_pkg;

   // Default width of the optional taken-branch counter
   localparam int CNT_W_DEF = 16;

   // Condition-code encodings carried on cond_sel
   localparam logic [2:0] COND_NEVER  = 3'b000;
   localparam logic [2:0] COND_ALWAYS = 3'b001;
   localparam logic [2:0] COND_REL    = 3'b010;
   localparam logic [2:0] COND_NREL   = 3'b011;
   localparam logic [2:0] COND_Z      = 3'b100;
   localparam logic [2:0] COND_NZ     = 3'b101;
   localparam logic [2:0] COND_N      = 3'b110;
   localparam logic [2:0] COND_NN     = 3'b111;

   // Controller states: IDLE holds no flags, LOADED holds valid flags,
   // EVAL computes the condition, DONE presents the result for one cycle
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOADED = 2'd1,
      ST_EVAL   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage : branch_cond_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational condition evaluator. Maps a 3-bit
//               condition code and the held relational flags onto a single
//               taken/not-taken decision.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
   import branch_cond_pkg::*;
(
   input  logic [2:0] cond_sel_i,
   input  logic       rel_i,
   input  logic       z_i,
   input  logic       n_i,
   output logic       taken_o
);

   // Decode the condition code against the flags
   always_comb begin
      taken_o = 1'b0;
      case (cond_sel_i)
         COND_NEVER:  taken_o = 1'b0;
         COND_ALWAYS: taken_o = 1'b1;
         COND_REL:    taken_o = rel_i;
         COND_NREL:   taken_o = ~rel_i;
         COND_Z:      taken_o = z_i;
         COND_NZ:     taken_o = ~z_i;
         COND_N:      taken_o = n_i;
         COND_NN:     taken_o = ~n_i;
         default:     taken_o = 1'b0;
      endcase
   end

endmodule : cond_eval
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_unit
// Description : Captures relational flags through a valid/ready handshake,
//               evaluates a requested branch condition against them and
//               reports the result with a one-cycle eval_done pulse.
//               Optional feature macro TAKEN_CNT_EN adds a saturating
//               taken-branch counter on port taken_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_unit
   import branch_cond_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             flag_valid,
   output logic             flag_ready,
   input  logic             rel_in,
   input  logic             z_in,
   input  logic             n_in,
   input  logic             eval_req,
   input  logic [2:0]       cond_sel,
   output logic             eval_done,
   output logic             branch_taken,
   output logic             rel_q,
   output logic             z_q,
   output logic             n_q
`ifdef TAKEN_CNT_EN
   ,
   output logic [CNT_W-1:0] taken_cnt
`endif
);

   state_e     state_q;
   state_e     state_d;
   logic [2:0] cond_q;
   logic       flags_vld_q;
   logic       branch_taken_q;
   logic       w_capture;
   logic       w_taken;

   // Flags are accepted only while no evaluation is in flight; reset blocks
   // acceptance immediately so upstream never hands off into a reset edge
   assign flag_ready   = ~rst & ((state_q == ST_IDLE) | (state_q == ST_LOADED));
   assign w_capture    = flag_valid & flag_ready;

   // DONE lasts exactly one cycle; a reset arriving in DONE suppresses it
   assign eval_done    = ~rst & (state_q == ST_DONE);
   assign branch_taken = branch_taken_q;

   // Next-state logic for the evaluation controller
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            // A pending eval_req is deliberately ignored until flags exist
            if (w_capture) state_d = ST_LOADED;
         end
         ST_LOADED: begin
            if (eval_req && (flags_vld_q || w_capture)) state_d = ST_EVAL;
         end
         ST_EVAL:  state_d = ST_DONE;
         ST_DONE:  state_d = ST_LOADED;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Flag capture; a capture coinciding with eval acceptance lands on the
   // same edge, so EVAL always sees the newest flags
   always_ff @(posedge clk) begin
      if (rst) begin
         rel_q       <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         flags_vld_q <= 1'b0;
      end else if (w_capture) begin
         rel_q       <= rel_in;
         z_q         <= z_in;
         n_q         <= n_in;
         flags_vld_q <= 1'b1;
      end
   end

   // Latch the condition code on the edge the request is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         cond_q <= COND_NEVER;
      end else if ((state_q == ST_LOADED) && (state_d == ST_EVAL)) begin
         cond_q <= cond_sel;
      end
   end

   cond_eval u_cond_eval (
      .cond_sel_i (cond_q),
      .rel_i      (rel_q),
      .z_i        (z_q),
      .n_i        (n_q),
      .taken_o    (w_taken)
   );

   // Result register: written leaving EVAL, held until the next evaluation
   always_ff @(posedge clk) begin
      if (rst)                      branch_taken_q <= 1'b0;
      else if (state_q == ST_EVAL)  branch_taken_q <= w_taken;
   end

`ifdef TAKEN_CNT_EN
   // Saturating count of DONE cycles that reported a taken branch
   always_ff @(posedge clk) begin
      if (rst) begin
         taken_cnt <= '0;
      end else if ((state_q == ST_DONE) && branch_taken_q && (taken_cnt != {CNT_W{1'b1}})) begin
         taken_cnt <= taken_cnt + CNT_W'(1);
      end
   end
`else
   // Counter width has no effect when the counter is not built
   logic w_unused_cnt_w;
   assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule : branch_cond_unit
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_cond_unit
// Description : Directed self-checking bench for branch_cond_unit. Counter
//               checks are included when TAKEN_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_cond_unit;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             flag_valid;
   logic             flag_ready;
   logic             rel_in, z_in, n_in;
   logic             eval_req;
   logic [2:0]       cond_sel;
   logic             eval_done;
   logic             branch_taken;
   logic             rel_q, z_q, n_q;
`ifdef TAKEN_CNT_EN
   logic [CNT_W-1:0] taken_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   branch_cond_unit #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .flag_valid   (flag_valid),
      .flag_ready   (flag_ready),
      .rel_in       (rel_in),
      .z_in         (z_in),
      .n_in         (n_in),
      .eval_req     (eval_req),
      .cond_sel     (cond_sel),
      .eval_done    (eval_done),
      .branch_taken (branch_taken),
      .rel_q        (rel_q),
      .z_q          (z_q),
      .n_q          (n_q)
`ifdef TAKEN_CNT_EN
      ,
      .taken_cnt    (taken_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present flags for exactly one capture edge
   task automatic load_flags(input logic r, input logic z, input logic n);
      flag_valid = 1'b1; rel_in = r; z_in = z; n_in = n;
      tick();
      flag_valid = 1'b0;
   endtask

   // One full evaluation from LOADED: EVAL, DONE, back to LOADED
   task automatic do_eval(input string tag, input logic [2:0] sel, input logic exp);
      eval_req = 1'b1; cond_sel = sel;
      tick();
      chk({tag, "_eval_nodone"}, 32'(eval_done), 32'd0);
      tick();
      chk({tag, "_done"},  32'(eval_done),    32'd1);
      chk({tag, "_taken"}, 32'(branch_taken), 32'(exp));
      eval_req = 1'b0;
      tick();
      chk({tag, "_done_drop"}, 32'(eval_done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flag_valid = 1'b0; rel_in = 1'b0; z_in = 1'b0; n_in = 1'b0;
      eval_req = 1'b0; cond_sel = 3'b000;
      tick(); tick();
      chk("rst_ready",  32'(flag_ready),   32'd0);
      chk("rst_rel",    32'(rel_q),        32'd0);
      chk("rst_done",   32'(eval_done),    32'd0);
      chk("rst_taken",  32'(branch_taken), 32'd0);
      rst = 1'b0; #1;
      chk("idle_ready", 32'(flag_ready),   32'd1);

      // First capture: rel=1
      load_flags(1'b1, 1'b0, 1'b0);
      chk("cap_rel",    32'(rel_q),      32'd1);
      chk("cap_z",      32'(z_q),        32'd0);
      chk("load_ready", 32'(flag_ready), 32'd1);

      // rel_q and its inverse
      do_eval("rel", 3'b010, 1'b1);
      chk("taken_held", 32'(branch_taken), 32'd1);
      do_eval("nrel", 3'b011, 1'b0);
      do_eval("never",  3'b000, 1'b0);
      do_eval("nz",     3'b101, 1'b1);

      // Back-to-back evaluations with eval_req held high: period of 3 cycles
      eval_req = 1'b1; cond_sel = 3'b001;
      tick(); tick();
      chk("b2b_done1", 32'(eval_done), 32'd1);
      tick();
      chk("b2b_gap1",  32'(eval_done), 32'd0);
      tick();
      chk("b2b_gap2",  32'(eval_done), 32'd0);
      tick();
      chk("b2b_done2", 32'(eval_done), 32'd1);
      chk("b2b_taken", 32'(branch_taken), 32'd1);
      eval_req = 1'b0;
      tick();

      // Flags offered during EVAL must wait until LOADED
      eval_req = 1'b1; cond_sel = 3'b010;
      tick();
      flag_valid = 1'b1; rel_in = 1'b0; z_in = 1'b0; n_in = 1'b0; #1;
      chk("eval_ready", 32'(flag_ready), 32'd0);
      tick();
      chk("done_ready", 32'(flag_ready),   32'd0);
      chk("hold_rel1",  32'(rel_q),        32'd1);
      chk("hold_taken", 32'(branch_taken), 32'd1);
      eval_req = 1'b0;
      tick();
      chk("hold_rel2",  32'(rel_q),      32'd1);
      chk("reld_ready", 32'(flag_ready), 32'd1);
      tick();
      flag_valid = 1'b0;
      chk("late_cap_rel", 32'(rel_q), 32'd0);

      // Reset in DONE suppresses the pulse and returns to IDLE
      eval_req = 1'b1; cond_sel = 3'b001;
      tick(); tick();
      rst = 1'b1; #1;
      chk("rst_done_sup", 32'(eval_done), 32'd0);
      eval_req = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst_done_taken", 32'(branch_taken), 32'd0);

      // eval_req in IDLE is ignored until flags arrive
      eval_req = 1'b1; cond_sel = 3'b100;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_req_nodone", 32'(eval_done), 32'd0);
      end
      load_flags(1'b0, 1'b1, 1'b0);
      chk("idle_cap_z",     32'(z_q),       32'd1);
      chk("idle_cap_nodone",32'(eval_done), 32'd0);
      tick();
      chk("idle_eval_nodone", 32'(eval_done), 32'd0);
      tick();
      chk("idle_z_done",  32'(eval_done),    32'd1);
      chk("idle_z_taken", 32'(branch_taken), 32'd1);
      eval_req = 1'b0;
      tick();

      // Same-edge capture (n=1) and request for n_q, with n_q previously 0
      chk("pre_n", 32'(n_q), 32'd0);
      flag_valid = 1'b1; rel_in = 1'b0; z_in = 1'b0; n_in = 1'b1;
      eval_req = 1'b1; cond_sel = 3'b110;
      tick();
      flag_valid = 1'b0;
      chk("same_n_q",    32'(n_q),       32'd1);
      chk("same_nodone", 32'(eval_done), 32'd0);
      tick();
      chk("same_done",  32'(eval_done),    32'd1);
      chk("same_taken", 32'(branch_taken), 32'd1);
      eval_req = 1'b0;
      tick();
      do_eval("nn", 3'b111, 1'b0);

`ifdef TAKEN_CNT_EN
      rst = 1'b1; tick(); rst = 1'b0;
      chk("cnt_rst", 32'(taken_cnt), 32'd0);
      load_flags(1'b1, 1'b0, 1'b0);
      do_eval("cnt_nt", 3'b000, 1'b0);
      chk("cnt_nt_val", 32'(taken_cnt), 32'd0);
      do_eval("cnt1", 3'b001, 1'b1); chk("cnt_1", 32'(taken_cnt), 32'd1);
      do_eval("cnt2", 3'b010, 1'b1); chk("cnt_2", 32'(taken_cnt), 32'd2);
      do_eval("cnt3", 3'b001, 1'b1); chk("cnt_3", 32'(taken_cnt), 32'd3);
      do_eval("cnt4", 3'b001, 1'b1); chk("cnt_4", 32'(taken_cnt), 32'd3);
      do_eval("cnt5", 3'b001, 1'b1); chk("cnt_5", 32'(taken_cnt), 32'd3);
      // Reset mid-EVAL: no pulse, counter cleared
      eval_req = 1'b1; cond_sel = 3'b001;
      tick();
      rst = 1'b1;
      tick();
      chk("abort_nodone", 32'(eval_done), 32'd0);
      chk("abort_cnt",    32'(taken_cnt), 32'd0);
      eval_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("abort_idle_nodone", 32'(eval_done), 32'd0);
      chk("abort_cnt2",        32'(taken_cnt), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_branch_cond_unit
`default_nettype wire
